// File: rtl/e_mdu_if.sv
// e_mdu_if: operand/op bus between the D->E register and the multiply/divide unit.
interface e_mdu_if;
  logic [31:0] E_O1;
  logic [31:0] E_O2;
  logic [3:0] MDUOp;
  logic Req;
  logic Busy;
  logic [31:0] MDU_O;
  modport master(output E_O1, E_O2, MDUOp, Req, input Busy, MDU_O);
  modport slave(input E_O1, E_O2, MDUOp, Req, output Busy, MDU_O);
endinterface

// File: rtl/e_mdu.sv
// e_mdu: multi-cycle MULT/DIV unit holding HI/LO; results commit when the countdown expires.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic clk,
  input logic reset,
  e_mdu_if.slave bus
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  logic [CW-1:0] cnt;
  logic [31:0] hi, lo, a, b;
  logic [2:0] op;
  logic busy, issue, sg, na, nb;
  logic [63:0] xa, xb, prod;
  logic [31:0] ua, ub, uq, ur, q, r;
  // One datapath serves both signednesses: sign-extend for MULT/DIV, zero-extend otherwise.
  always_comb begin
    busy = cnt != '0;
    issue = bus.MDUOp inside {[4'd1:4'd6]} && !bus.Req && !busy;
    sg = op == 3'd1 || op == 3'd3;
    xa = {{32{sg & a[31]}}, a};
    xb = {{32{sg & b[31]}}, b};
    prod = xa * xb;
    na = sg & a[31];
    nb = sg & b[31];
    ua = na ? -a : a;
    ub = b == '0 ? 32'd1 : nb ? -b : b;
    uq = ua / ub;
    ur = ua % ub;
    q = na ^ nb ? -uq : uq;
    r = na ? -ur : ur;
  end
  assign bus.Busy = busy;
  assign bus.MDU_O = bus.MDUOp == 4'd7 ? hi : bus.MDUOp == 4'd8 ? lo : 32'd0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      {hi, lo, a, b, op} <= '0;
      cnt <= '0;
    end else begin
      if (busy) cnt <= cnt - 1'b1;
      if (issue) begin
        if (bus.MDUOp == 4'd5) hi <= bus.E_O1;
        else if (bus.MDUOp == 4'd6) lo <= bus.E_O1;
        else begin
          a <= bus.E_O1;
          b <= bus.E_O2;
          op <= bus.MDUOp[2:0];
          cnt <= bus.MDUOp < 4'd3 ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end
      end
      if (cnt == CW'(1)) begin
        if (op < 3'd3) {hi, lo} <= prod;
        else if (b != '0) begin
          lo <= q;
          hi <= r;
        end
      end
    end
  // The hazard unit must hold MD/MT ops off while an operation is in flight.
  assert property (@(posedge clk) disable iff (!reset) busy |-> !(bus.MDUOp inside {[4'd1:4'd6]}));
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: scoreboard bench; stimulus pushes per-cycle expected Busy/MDU_O, monitor compares.
module tb_e_mdu;
  localparam int MC = 5;
  localparam int DC = 10;
  logic clk = 0;
  logic reset = 0;
  always #5 clk = ~clk;
  e_mdu_if bus();
  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut(.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic busy;
    logic [31:0] o;
    int id;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int compared = 0;
  int mismatched = 0;
  int n = 0;
  logic [31:0] mhi = 0, mlo = 0, phi = 0, plo = 0;
  int rem = 0;
  bit pv = 0;
  task automatic model_issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx = $signed(x);
    longint sy = $signed(y);
    longint ux = {32'd0, x};
    longint uy = {32'd0, y};
    logic [63:0] p;
    case (op)
      4'd1: begin p = sx * sy; {phi, plo} = p; pv = 1; rem = MC; end
      4'd2: begin p = ux * uy; {phi, plo} = p; pv = 1; rem = MC; end
      4'd3: begin pv = y != 0; if (pv) begin plo = 32'(sx / sy); phi = 32'(sx % sy); end rem = DC; end
      4'd4: begin pv = y != 0; if (pv) begin plo = 32'(ux / uy); phi = 32'(ux % uy); end rem = DC; end
      4'd5: mhi = x;
      default: mlo = x;
    endcase
  endtask
  task automatic step(input logic [3:0] op, input logic [31:0] x = 0, input logic [31:0] y = 0,
                      input bit rq = 0, input bit rn = 1);
    @(posedge clk);
    #1;
    reset = rn;
    bus.MDUOp = op;
    bus.E_O1 = x;
    bus.E_O2 = y;
    bus.Req = rq;
    if (!rn) begin mhi = 0; mlo = 0; rem = 0; pv = 0; end
    sb.push_back('{rem > 0, op == 4'd7 ? mhi : op == 4'd8 ? mlo : 32'd0, n++});
    if (!rn) return;
    if (rem > 0) begin
      rem--;
      if (rem == 0 && pv) begin mhi = phi; mlo = plo; end
    end else if (!rq && op >= 4'd1 && op <= 4'd6) model_issue(op, x, y);
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(4'd0);
  endtask
  always @(negedge clk)
    if (sb.size() > 0) begin
      e = sb.pop_front();
      compared++;
      if (bus.Busy !== e.busy) begin
        mismatched++;
        $display("FAIL busy step %0d: got %b want %b", e.id, bus.Busy, e.busy);
      end
      compared++;
      if (bus.MDU_O !== e.o) begin
        mismatched++;
        $display("FAIL mdu_o step %0d: got %h want %h", e.id, bus.MDU_O, e.o);
      end
    end
  initial begin
    logic [31:0] sp[6];
    logic [3:0] op;
    logic [31:0] x, y;
    sp = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h10000};
    bus.MDUOp = 0; bus.E_O1 = 0; bus.E_O2 = 0; bus.Req = 0;
    step(4'd7, 0, 0, 0, 0);
    step(4'd8, 0, 0, 0, 0);
    step(4'd7);
    step(4'd8);
    step(4'd1, 32'hFFFFFFFE, 3); idle(MC); step(4'd7); step(4'd8);
    step(4'd2, 32'hFFFFFFFE, 3); idle(MC); step(4'd7); step(4'd8);
    step(4'd3, 32'hFFFFFFF9, 2); idle(DC); step(4'd8); step(4'd7);
    step(4'd3, 32'hFFFFFFF9, 0); idle(DC); step(4'd8); step(4'd7);
    step(4'd3, 32'h80000000, 32'hFFFFFFFF); idle(DC); step(4'd8); step(4'd7);
    step(4'd5, 32'h12345678, 0, 1); step(4'd7);
    step(4'd1, 32'h7, 32'h9, 1); step(4'd0); step(4'd7); step(4'd8);
    step(4'd4, 100, 7);
    for (int i = 1; i <= DC; i++) step(4'd0, 0, 0, i == 4);
    step(4'd6, 32'hA5A5A5A5); step(4'd8); step(4'd7);
    step(4'd2, 32'h10000, 32'h10000); step(4'd0);
    step(4'd0, 0, 0, 0, 0); step(4'd0); step(4'd7); step(4'd8);
    for (int i = 0; i < 400; i++) begin
      x = $urandom_range(0, 3) == 0 ? sp[$urandom_range(0, 5)] : $urandom;
      y = $urandom_range(0, 3) == 0 ? sp[$urandom_range(0, 5)] : $urandom;
      if (rem > 0) op = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(9, 15));
      else op = 4'($urandom_range(0, 15));
      step(op, x, y, $urandom_range(0, 7) == 0);
    end
    idle(1);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
